// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter family.
// Mode encodings and a constant log2 helper for register sizing.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Ceiling log2, never below 1 so a register is always at least 1 bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles.
// With PRESCALE=1 the tick is the enable itself.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = clog2(PRESCALE);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (PRESCALE <= 1) || (r_cnt == PW'(PRESCALE - 1));
    assign tick   = enable && w_last;

    // Count enabled cycles, rolling over on the tick; clear restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with limits, step, wrap/saturate/one-shot
// modes, prescaled enable, terminal-count pulse and sticky boundary flags.
module prog_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit_lo,
    input  logic [WIDTH-1:0]  limit_hi,
    input  logic [1:0]        mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count_out,
    output logic              tc_pulse,
    output logic              ovf_flag,
    output logic              unf_flag,
    output logic              running
);

    localparam int EW = WIDTH + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic             r_run;

    logic             w_tick;
    logic             w_pre_en;
    logic             w_adv;
    logic             w_sat;
    logic             w_evt;
    logic [EW-1:0]    w_step_ext;
    logic [EW-1:0]    w_sum;
    logic [EW-1:0]    w_lo_step;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_cnt_nxt;

    // Stopped one-shot and load cycles do not feed the prescaler.
    assign w_pre_en = enable && r_run && !load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk    (clk),
        .reset  (reset),
        .enable (w_pre_en),
        .clear  (load),
        .tick   (w_tick)
    );

    // Extended-width arithmetic so neither direction can alias.
    assign w_step_ext = EW'(step);
    assign w_sum      = {1'b0, r_count} + w_step_ext;
    assign w_lo_step  = {1'b0, limit_lo} + w_step_ext;
    assign w_dn       = r_count - WIDTH'(step);

    // Inverted limits or zero step make the advance a no-op.
    assign w_adv = w_tick && (limit_lo <= limit_hi) && (|step);
    assign w_sat = (mode == MODE_SAT) || (mode == MODE_ONESHOT);
    assign w_evt = w_adv &&
                   (up ? (w_sum > {1'b0, limit_hi})
                       : ({1'b0, r_count} < w_lo_step));

    // Next count: load, boundary target by mode, or plain step.
    always_comb begin
        w_cnt_nxt = r_count;
        if (load) begin
            w_cnt_nxt = load_in;
        end else if (w_evt) begin
            if (up) begin
                w_cnt_nxt = w_sat ? limit_hi : limit_lo;
            end else begin
                w_cnt_nxt = w_sat ? limit_lo : limit_hi;
            end
        end else if (w_adv) begin
            w_cnt_nxt = up ? w_sum[WIDTH-1:0] : w_dn;
        end
    end

    // Count, pulse, sticky flags and one-shot run state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_run   <= 1'b1;
        end else begin
            r_count <= w_cnt_nxt;
            r_tc    <= w_evt;
            r_ovf   <= (w_evt && up) || (r_ovf && !clr_flags);
            r_unf   <= (w_evt && !up) || (r_unf && !clr_flags);
            if (load) begin
                r_run <= 1'b1;
            end else if (w_evt && (mode == MODE_ONESHOT)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign count_out = r_count;
    assign tc_pulse  = r_tc;
    assign ovf_flag  = r_ovf;
    assign unf_flag  = r_unf;
    assign running   = r_run;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Bench for prog_updown_counter: directed scenarios plus randomized
// traffic against an integer reference model, PRESCALE 1 and 4 instances.
module tb_prog_updown_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up;
    logic       load;
    logic [7:0] load_in;
    logic [3:0] step;
    logic [7:0] limit_lo;
    logic [7:0] limit_hi;
    logic [1:0] mode;
    logic       clr_flags;

    logic [7:0] c0, c4;
    logic       tc0, ov0, un0, rn0;
    logic       tc4, ov4, un4, rn4;

    int n_vec;
    int n_err;

    int m_cnt [2];
    int m_pre [2];
    bit m_run [2];
    bit m_ovf [2];
    bit m_unf [2];
    bit m_tc  [2];

    prog_updown_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_in(load_in), .step(step), .limit_lo(limit_lo),
        .limit_hi(limit_hi), .mode(mode), .clr_flags(clr_flags),
        .count_out(c0), .tc_pulse(tc0), .ovf_flag(ov0), .unf_flag(un0),
        .running(rn0)
    );

    prog_updown_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_in(load_in), .step(step), .limit_lo(limit_lo),
        .limit_hi(limit_hi), .mode(mode), .clr_flags(clr_flags),
        .count_out(c4), .tc_pulse(tc4), .ovf_flag(ov4), .unf_flag(un4),
        .running(rn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset(input int k);
        m_cnt[k] = 0;
        m_pre[k] = 0;
        m_run[k] = 1;
        m_ovf[k] = 0;
        m_unf[k] = 0;
        m_tc[k]  = 0;
    endtask

    // Reference behaviour for one clock edge, in plain integer arithmetic.
    task automatic model_edge(input int k, input int ps);
        int c, lo, hi, st, nx;
        bit ev, adv;
        if (reset) begin
            model_reset(k);
            return;
        end
        c = m_cnt[k]; lo = limit_lo; hi = limit_hi; st = step;
        ev = 0; adv = 0; nx = c;
        if (load) begin
            nx = load_in;
            m_run[k] = 1;
            m_pre[k] = 0;
        end else if (enable && m_run[k]) begin
            m_pre[k] = m_pre[k] + 1;
            if (m_pre[k] == ps) begin
                m_pre[k] = 0;
                adv = 1;
            end
        end
        if (adv && lo <= hi && st != 0) begin
            if (up) begin
                nx = c + st;
                ev = (nx > hi);
            end else begin
                nx = c - st;
                ev = (c - st < lo);
            end
            if (ev) begin
                if (mode == 2'd1 || mode == 2'd2) nx = up ? hi : lo;
                else nx = up ? lo : hi;
                if (mode == 2'd2) m_run[k] = 0;
            end
        end
        m_cnt[k] = nx;
        m_tc[k]  = ev;
        m_ovf[k] = (ev && up) ? 1'b1 : (clr_flags ? 1'b0 : m_ovf[k]);
        m_unf[k] = (ev && !up) ? 1'b1 : (clr_flags ? 1'b0 : m_unf[k]);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge(0, 1);
        model_edge(1, 4);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd0 || tc0 !== 1'b0 || ov0 !== 1'b0 || un0 !== 1'b0 || rn0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got cnt=%h tc=%b ovf=%b unf=%b run=%b, want 00 0 0 0 1",
                     c0, tc0, ov0, un0, rn0);
        end
        reset = 1'b0;
        load = 1'b1;
        load_in = 8'h37;
        tick_cycle();
        load = 1'b0;
        n_vec++;
        if (c0 !== 8'h37) begin
            n_err++;
            $display("FAIL reset_preload: got %h want 37", c0);
        end
        #2 reset = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        n_vec++;
        if (c0 !== 8'd0 || rn0 !== 1'b1 || ov0 !== 1'b0 || un0 !== 1'b0 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got cnt=%h run=%b ovf=%b unf=%b tc=%b, want 00 1 0 0 0",
                     c0, rn0, ov0, un0, tc0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        mode = 2'b00; limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd3; up = 1'b1;
        load = 1'b1; load_in = 8'd18; clr_flags = 1'b1; enable = 1'b0;
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd18) begin
            n_err++;
            $display("FAIL wrap_load: got %0d want 18", c0);
        end
        load = 1'b0; clr_flags = 1'b0; enable = 1'b1;
        tick_cycle();
        enable = 1'b0;
        n_vec++;
        if (c0 !== 8'd10 || tc0 !== 1'b1 || ov0 !== 1'b1 || un0 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_event: got cnt=%0d tc=%b ovf=%b unf=%b, want 10 1 1 0",
                     c0, tc0, ov0, un0);
        end
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd10 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pulse_end: got cnt=%0d tc=%b, want 10 0", c0, tc0);
        end
    endtask

    task automatic test_saturate();
        mode = 2'b01; limit_lo = 8'd5; limit_hi = 8'd200; step = 4'd4; up = 1'b0;
        load = 1'b1; load_in = 8'd7; enable = 1'b0;
        tick_cycle();
        load = 1'b0; enable = 1'b1;
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd5 || tc0 !== 1'b1 || un0 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_event: got cnt=%0d tc=%b unf=%b, want 5 1 1", c0, tc0, un0);
        end
        tick_cycle();
        enable = 1'b0;
        n_vec++;
        if (c0 !== 8'd5 || tc0 !== 1'b1 || rn0 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_repeat: got cnt=%0d tc=%b run=%b, want 5 1 1", c0, tc0, rn0);
        end
    endtask

    task automatic test_oneshot();
        mode = 2'b10; limit_lo = 8'd0; limit_hi = 8'd15; step = 4'd1; up = 1'b1;
        load = 1'b1; load_in = 8'd14; enable = 1'b0;
        tick_cycle();
        load = 1'b0; enable = 1'b1;
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd15 || tc0 !== 1'b0 || rn0 !== 1'b1) begin
            n_err++;
            $display("FAIL os_reach_hi: got cnt=%0d tc=%b run=%b, want 15 0 1", c0, tc0, rn0);
        end
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd15 || tc0 !== 1'b1 || rn0 !== 1'b0 || ov0 !== 1'b1) begin
            n_err++;
            $display("FAIL os_stop: got cnt=%0d tc=%b run=%b ovf=%b, want 15 1 0 1",
                     c0, tc0, rn0, ov0);
        end
        tick_cycle();
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd15 || tc0 !== 1'b0 || rn0 !== 1'b0) begin
            n_err++;
            $display("FAIL os_frozen: got cnt=%0d tc=%b run=%b, want 15 0 0", c0, tc0, rn0);
        end
        load = 1'b1; load_in = 8'd3;
        tick_cycle();
        load = 1'b0;
        n_vec++;
        if (c0 !== 8'd3 || rn0 !== 1'b1) begin
            n_err++;
            $display("FAIL os_reload: got cnt=%0d run=%b, want 3 1", c0, rn0);
        end
        tick_cycle();
        enable = 1'b0;
        n_vec++;
        if (c0 !== 8'd4) begin
            n_err++;
            $display("FAIL os_resume: got %0d want 4", c0);
        end
    endtask

    task automatic test_prescale();
        int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 9, 9};
        bit en_seq  [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        bit ld_seq  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        mode = 2'b00; limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd1; up = 1'b1;
        load = 1'b1; load_in = 8'd0; enable = 1'b0;
        tick_cycle();
        load_in = 8'd9;
        for (int i = 0; i < 13; i++) begin
            enable = en_seq[i];
            load = ld_seq[i];
            tick_cycle();
            n_vec++;
            if (c4 !== 8'(exp_seq[i])) begin
                n_err++;
                $display("FAIL prescale_step%0d: got %0d want %0d", i, c4, exp_seq[i]);
            end
        end
        load = 1'b0; enable = 1'b1;
        tick_cycle();
        tick_cycle();
        n_vec++;
        if (c4 !== 8'd9) begin
            n_err++;
            $display("FAIL prescale_after_load: got %0d want 9", c4);
        end
        tick_cycle();
        enable = 1'b0;
        n_vec++;
        if (c4 !== 8'd10) begin
            n_err++;
            $display("FAIL prescale_reload_adv: got %0d want 10", c4);
        end
    endtask

    task automatic test_simultaneous();
        mode = 2'b00; limit_lo = 8'd10; limit_hi = 8'd20; step = 4'd1; up = 1'b1;
        load = 1'b1; load_in = 8'd20; enable = 1'b1; clr_flags = 1'b1;
        tick_cycle();
        load = 1'b0;
        n_vec++;
        if (c0 !== 8'd20 || ov0 !== 1'b0 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL load_wins: got cnt=%0d ovf=%b tc=%b, want 20 0 0", c0, ov0, tc0);
        end
        tick_cycle();
        n_vec++;
        if (c0 !== 8'd10 || ov0 !== 1'b1 || tc0 !== 1'b1) begin
            n_err++;
            $display("FAIL set_beats_clr: got cnt=%0d ovf=%b tc=%b, want 10 1 1", c0, ov0, tc0);
        end
        enable = 1'b0;
        tick_cycle();
        clr_flags = 1'b0;
        n_vec++;
        if (ov0 !== 1'b0 || un0 !== 1'b0) begin
            n_err++;
            $display("FAIL clr_flags: got ovf=%b unf=%b, want 0 0", ov0, un0);
        end
        limit_lo = 8'd30; limit_hi = 8'd20; enable = 1'b1;
        tick_cycle();
        tick_cycle();
        enable = 1'b0;
        n_vec++;
        if (c0 !== 8'd10 || tc0 !== 1'b0 || ov0 !== 1'b0) begin
            n_err++;
            $display("FAIL inverted_limits: got cnt=%0d tc=%b ovf=%b, want 10 0 0", c0, tc0, ov0);
        end
    endtask

    task automatic test_random();
        int lo, span;
        for (int i = 0; i < 600; i++) begin
            if (i % 16 == 0) begin
                lo = $urandom_range(0, 200);
                span = $urandom_range(0, 50);
                limit_lo = 8'(lo);
                limit_hi = 8'((lo + span > 255) ? 255 : lo + span);
                if ($urandom_range(0, 9) == 0) begin
                    limit_lo = 8'(lo + span + 1);
                end
                mode = 2'($urandom_range(0, 3));
            end
            load      = ($urandom_range(0, 9) == 0);
            load_in   = 8'($urandom_range(0, 255));
            enable    = ($urandom_range(0, 3) != 0);
            up        = 1'($urandom_range(0, 1));
            step      = 4'($urandom_range(0, 15));
            clr_flags = ($urandom_range(0, 7) == 0);
            tick_cycle();
            n_vec++;
            if (c0 !== 8'(m_cnt[0]) || tc0 !== m_tc[0] || ov0 !== m_ovf[0] ||
                un0 !== m_unf[0] || rn0 !== m_run[0]) begin
                n_err++;
                $display("FAIL rand_p1 #%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         c0, tc0, ov0, un0, rn0,
                         8'(m_cnt[0]), m_tc[0], m_ovf[0], m_unf[0], m_run[0]);
            end
            n_vec++;
            if (c4 !== 8'(m_cnt[1]) || tc4 !== m_tc[1] || ov4 !== m_ovf[1] ||
                un4 !== m_unf[1] || rn4 !== m_run[1]) begin
                n_err++;
                $display("FAIL rand_p4 #%0d: got %h %b%b%b%b want %h %b%b%b%b", i,
                         c4, tc4, ov4, un4, rn4,
                         8'(m_cnt[1]), m_tc[1], m_ovf[1], m_unf[1], m_run[1]);
            end
        end
        load = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        enable = 1'b0; up = 1'b1; load = 1'b0; load_in = '0;
        step = '0; limit_lo = '0; limit_hi = '0; mode = '0; clr_flags = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        test_reset();
        test_wrap();
        test_saturate();
        test_oneshot();
        test_prescale();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
